dac_frame_receiver: RTL and testbench
=====================================

Name: dac_frame_receiver

Overview:
- Serial responder for the DAC write link: the slave end of the sync/din/clk_out frame the DAC driver emits.
- Oversamples the link in the system clock domain and deserialises 16-bit frames, MSB first.
- Decodes the word as DAC format: bit15 control flag, bits14:12 channel, bits11:0 data.
- Holds a per-channel shadow register file for on-chip loopback checking of the multipath DAC scan, with registered readback.

Parameters:
- WORD_W, 16, bits per frame.
- NUM_CH, 8, channels in the shadow file (address field is 3 bits).
- SYNC_STAGES, 2, flip-flop stages on each link input.

Ports:
- clk  in  1  system clock (200 MHz).
- rst  in  1  asynchronous, active-high reset.
- sync_in  in  1  frame enable from the DAC driver, active low.
- sclk_in  in  1  serial clock from the DAC driver.
- din_in  in  1  serial data from the DAC driver.
- word_out  out  16  last complete frame.
- word_valid  out  1  one-cycle strobe; word_out is valid.
- ctrl_flag  out  1  one-cycle strobe, coincident with word_valid when bit15=1.
- frame_err  out  1  one-cycle strobe on a malformed frame.
- rd_addr  in  3  shadow-file read address.
- rd_data  out  12  shadow-file data, 1-cycle read latency.

Behaviour:
- Reset: all synchroniser flops reset to 0. word_out, rd_data, all shadow registers, bit counter and shift register reset to 0. All strobes reset to 0. FSM resets to IDLE.
- Synchronisers: sync_in, sclk_in and din_in each pass through SYNC_STAGES flops, then one extra "previous" flop for edge detection.
  - Falling sclk edge: prev=1 and cur=0. din is taken from the same synchroniser stage as sclk, so both see equal delay.
- Link timing (met by the driver at 200/12 MHz): sclk high and low phases are each at least 3 clk periods. din is stable at least 3 clk periods around the sclk falling edge.
- FSM states: IDLE, SHIFT, WAIT_END.
  - IDLE: a sync falling edge clears the counter and shift register and goes to SHIFT. A sync rising edge or sclk activity is ignored.
  - SHIFT: each sclk falling edge shifts din into the LSB (left shift) and increments the counter. On the 16th edge, go to WAIT_END.
    - Sync rising edge with count<16: pulse frame_err, no commit, go to IDLE.
  - WAIT_END: any further sclk falling edge sets an internal overrun bit.
    - Sync rising edge with overrun=0 (commit): load word_out, pulse word_valid. If bit15=1, also pulse ctrl_flag and leave the shadow file unchanged. If bit15=0, write shadow[bits14:12] <= bits11:0. Then go to IDLE.
    - Sync rising edge with overrun=1: pulse frame_err, leave word_out and shadow unchanged, go to IDLE.
- Latency: count edge 1 as the first clk edge that samples sync_in high. The strobes are registered high after edge SYNC_STAGES+2, i.e. edge 4 at the default, and are high for exactly one cycle.
- Back-to-back frames: a sync falling edge arriving while a strobe is high is accepted normally. There is no minimum gap beyond the link timing.
- Readback: rd_data <= shadow[rd_addr] every cycle.
  - If the commit targets the same address in the same cycle, rd_data shows the old value (read-before-write). The new value appears one cycle later.
- Reset mid-frame: the frame is abandoned.
  - If sync is already low at release, no falling edge is detected. The rising edge that follows is ignored in IDLE.
  - Capture resumes at the next sync falling edge; no strobe is generated for the partial frame.
- Sync glitch: a low pulse shorter than 1 clk may be missed. This is not an error.

Test Plan:
- Write frame 0x3ABC with sclk half-period 6 clk → word_out=0x3ABC, word_valid one cycle at edge 4 after sync high, ctrl_flag=0. Then rd_addr=3 → rd_data=0xABC next cycle.
- Control frame 0xA000 → word_valid=1 and ctrl_flag=1 in the same cycle. All eight shadow registers unchanged; rd_addr=2 returns its prior value.
- Short frame of 10 bits then sync high → frame_err one cycle, word_valid=0, word_out keeps its previous value (0x3ABC).
- 17 sclk falling edges in one frame → frame_err. Then a clean frame 0x7FFF → shadow[7]=0xFFF, and rd_addr=7 reads 0xFFF.
- Reset asserted after 8 bits of frame 0x1123, released while sync is still low, remaining 8 bits sent → no strobe. The next full frame 0x1456 → shadow[1]=0x456.
- Eight back-to-back frames 0x0001..0x7008 with a 2-sclk gap → eight word_valid pulses, shadow[n]=n+1. Hold rd_addr=5 during its commit → rd_data 0x000 in the commit cycle, 0x006 the cycle after.

Source files
------------

// File: rtl/dac_frame_receiver.sv
// -----------------------------------------------------------------------------
// dac_frame_receiver
//
// Receives the sync/sclk/din write link that the DAC driver produces. The
// receiver oversamples the link in the system clock domain. It deserialises
// 16-bit frames, MSB first, and decodes each frame as a DAC word:
//   bit 15     control flag
//   bits 14:12 channel
//   bits 11:0  data
// Data words are written into a per-channel shadow register file. The scan
// logic reads that file back to check the multipath DAC scan on chip.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   sync_in    frame enable from the driver, active low
//   sclk_in    serial clock from the driver; data is taken on its falling edge
//   din_in     serial data from the driver
//   word_out   last complete frame that was committed
//   word_valid one-cycle strobe; word_out has just been loaded
//   ctrl_flag  one-cycle strobe together with word_valid when bit 15 is set
//   frame_err  one-cycle strobe for a short frame or an overrun frame
//   rd_addr    shadow-file read address
//   rd_data    shadow-file read data, one cycle after rd_addr
// -----------------------------------------------------------------------------
module dac_frame_receiver #(
    parameter int WORD_W      = 16,
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sync_in,
    input  logic                                sclk_in,
    input  logic                                din_in,
    output logic [WORD_W-1:0]                   word_out,
    output logic                                word_valid,
    output logic                                ctrl_flag,
    output logic                                frame_err,
    input  logic [$clog2(NUM_CH)-1:0]           rd_addr,
    output logic [WORD_W-2-$clog2(NUM_CH):0]    rd_data
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DATA_W = WORD_W - 1 - CH_W;
    localparam int CNT_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

    // Synchroniser chains. The top index is the synchronised "current" value.
    logic [SYNC_STAGES-1:0] sync_sr_q, sync_sr_d;
    logic [SYNC_STAGES-1:0] sclk_sr_q, sclk_sr_d;
    logic [SYNC_STAGES-1:0] din_sr_q,  din_sr_d;
    logic                   sync_prev_q, sync_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;

    // Registered link events. din is captured with the sclk event so that both
    // reach the FSM with the same delay.
    logic sync_fall_q, sync_fall_d;
    logic sync_rise_q, sync_rise_d;
    logic sclk_fall_q, sclk_fall_d;
    logic din_bit_q,   din_bit_d;

    // Frame state
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic                overrun_q, overrun_d;

    // Registered outputs
    logic [WORD_W-1:0]   word_out_q, word_out_d;
    logic                word_valid_q, word_valid_d;
    logic                ctrl_flag_q, ctrl_flag_d;
    logic                frame_err_q, frame_err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    // Shadow register file
    logic [DATA_W-1:0]   shadow_q [NUM_CH];
    logic [DATA_W-1:0]   shadow_d [NUM_CH];

    // Synchroniser shift, edge detection and event registration
    always_comb begin
        sync_sr_d   = {sync_sr_q[SYNC_STAGES-2:0], sync_in};
        sclk_sr_d   = {sclk_sr_q[SYNC_STAGES-2:0], sclk_in};
        din_sr_d    = {din_sr_q[SYNC_STAGES-2:0],  din_in};
        sync_prev_d = sync_sr_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_sr_q[SYNC_STAGES-1];
        sync_fall_d = sync_prev_q & ~sync_sr_q[SYNC_STAGES-1];
        sync_rise_d = ~sync_prev_q & sync_sr_q[SYNC_STAGES-1];
        sclk_fall_d = sclk_prev_q & ~sclk_sr_q[SYNC_STAGES-1];
        din_bit_d   = din_sr_q[SYNC_STAGES-1];
    end

    // Synchroniser and event flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_sr_q   <= '0;
            sclk_sr_q   <= '0;
            din_sr_q    <= '0;
            sync_prev_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            sync_fall_q <= 1'b0;
            sync_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            din_bit_q   <= 1'b0;
        end else begin
            sync_sr_q   <= sync_sr_d;
            sclk_sr_q   <= sclk_sr_d;
            din_sr_q    <= din_sr_d;
            sync_prev_q <= sync_prev_d;
            sclk_prev_q <= sclk_prev_d;
            sync_fall_q <= sync_fall_d;
            sync_rise_q <= sync_rise_d;
            sclk_fall_q <= sclk_fall_d;
            din_bit_q   <= din_bit_d;
        end
    end

    // Frame FSM: next state, deserialiser, commit and strobe generation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        overrun_d    = overrun_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        ctrl_flag_d  = 1'b0;
        frame_err_d  = 1'b0;
        shadow_d     = shadow_q;

        case (state_q)
            ST_IDLE: begin
                // A rising sync edge or sclk activity is ignored while idle.
                if (sync_fall_q) begin
                    cnt_d     = '0;
                    shift_d   = '0;
                    overrun_d = 1'b0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sync_rise_q) begin
                    // The frame ended before all bits arrived.
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (sclk_fall_q) begin
                    shift_d = {shift_q[WORD_W-2:0], din_bit_q};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WORD_W - 1)) begin
                        state_d = ST_WAIT_END;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_WAIT_END: begin
                if (sync_rise_q) begin
                    if (overrun_q) begin
                        frame_err_d = 1'b1;
                    end else begin
                        word_out_d   = shift_q;
                        word_valid_d = 1'b1;
                        if (shift_q[WORD_W-1]) begin
                            ctrl_flag_d = 1'b1;
                        end else begin
                            shadow_d[shift_q[WORD_W-2 -: CH_W]] = shift_q[DATA_W-1:0];
                        end
                    end
                    state_d = ST_IDLE;
                end else if (sclk_fall_q) begin
                    // Extra clock edges after a full word make the frame invalid.
                    overrun_d = 1'b1;
                    state_d   = ST_WAIT_END;
                end else begin
                    state_d   = ST_WAIT_END;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Readback reads the pre-commit contents, so a same-cycle write is visible one cycle later
    always_comb begin
        rd_data_d = shadow_q[rd_addr];
    end

    // Frame state, output and shadow-file registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            overrun_q    <= 1'b0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            ctrl_flag_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_data_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            overrun_q    <= overrun_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            ctrl_flag_q  <= ctrl_flag_d;
            frame_err_q  <= frame_err_d;
            rd_data_q    <= rd_data_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign ctrl_flag  = ctrl_flag_q;
    assign frame_err  = frame_err_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_dac_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_dac_frame_receiver
//
// Directed bench for dac_frame_receiver. Uses a table of single-frame vectors
// with their expected strobes, plus hand-written sequences for reset during a
// frame and for back-to-back frames. A small shadow-file model holds the
// expected readback values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dac_frame_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync_in;
    logic        sclk_in;
    logic        din_in;
    logic [15:0] word_out;
    logic        word_valid;
    logic        ctrl_flag;
    logic        frame_err;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] shadow_m [8];
    logic [15:0] word_m;

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        bit          exp_wv;
        bit          exp_cf;
        bit          exp_fe;
    } vec_t;

    vec_t vecs [5];

    dac_frame_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .sclk_in    (sclk_in),
        .din_in     (din_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .ctrl_flag  (ctrl_flag),
        .frame_err  (frame_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        sync_in = 1'b0;
        sclk_in = 1'b1;
        idle_clk(6);
    endtask

    // MSB first; din changes with sclk high and is stable through the falling edge.
    task automatic send_bits(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk_in = 1'b1;
            din_in  = val[i];
            idle_clk(6);
            sclk_in = 1'b0;
            idle_clk(6);
        end
        sclk_in = 1'b1;
        idle_clk(6);
    endtask

    // Raises sync and watches the next 8 cycles. k = n means sampled after clk edge n.
    task automatic end_frame(output int wv_cnt, output int wv_pos, output int cf_cnt,
                             output int cf_pos, output int fe_cnt, output int fe_pos,
                             output logic [11:0] rd4, output logic [11:0] rd5);
        wv_cnt = 0; wv_pos = 0; cf_cnt = 0; cf_pos = 0; fe_cnt = 0; fe_pos = 0;
        rd4 = '0; rd5 = '0;
        sync_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (word_valid === 1'b1) begin wv_cnt++; wv_pos = k; end
            if (ctrl_flag === 1'b1)  begin cf_cnt++; cf_pos = k; end
            if (frame_err === 1'b1)  begin fe_cnt++; fe_pos = k; end
            if (k == 4) rd4 = rd_data;
            if (k == 5) rd5 = rd_data;
        end
    endtask

    task automatic end_and_check(input string tag, input bit exp_wv, input bit exp_cf,
                                 input bit exp_fe, output logic [11:0] rd4,
                                 output logic [11:0] rd5);
        int wv_cnt, wv_pos, cf_cnt, cf_pos, fe_cnt, fe_pos;
        end_frame(wv_cnt, wv_pos, cf_cnt, cf_pos, fe_cnt, fe_pos, rd4, rd5);
        check({tag, " word_valid count"}, wv_cnt, exp_wv ? 1 : 0);
        check({tag, " word_valid cycle"}, wv_pos, exp_wv ? 4 : 0);
        check({tag, " ctrl_flag count"},  cf_cnt, exp_cf ? 1 : 0);
        check({tag, " ctrl_flag cycle"},  cf_pos, exp_cf ? 4 : 0);
        check({tag, " frame_err count"},  fe_cnt, exp_fe ? 1 : 0);
        check({tag, " frame_err cycle"},  fe_pos, exp_fe ? 4 : 0);
    endtask

    task automatic model_commit(input logic [15:0] frame);
        word_m = frame;
        if (frame[15] == 1'b0) begin
            shadow_m[frame[14:12]] = frame[11:0];
        end
    endtask

    task automatic model_reset();
        word_m = 16'h0000;
        for (int i = 0; i < 8; i++) shadow_m[i] = 12'h000;
    endtask

    task automatic check_state(input string tag);
        check({tag, " word_out"}, word_out, word_m);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            @(negedge clk);
            check($sformatf("%s rd_data[%0d]", tag, a), rd_data, shadow_m[a]);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rd4, rd5;
        logic [15:0] fr;

        vecs[0] = '{32'h0000_3ABC, 16, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0155, 10, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_A000, 16, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h0001_FFFF, 17, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_7FFF, 16, 1'b1, 1'b0, 1'b0};

        rst     = 1'b1;
        sync_in = 1'b1;
        sclk_in = 1'b1;
        din_in  = 1'b0;
        rd_addr = 3'd0;
        model_reset();

        idle_clk(3);
        check("reset word_out",   word_out,   16'h0000);
        check("reset word_valid", word_valid, 1'b0);
        check("reset ctrl_flag",  ctrl_flag,  1'b0);
        check("reset frame_err",  frame_err,  1'b0);
        check("reset rd_data",    rd_data,    12'h000);
        rst = 1'b0;
        idle_clk(6);
        check_state("after reset");

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            start_frame();
            send_bits(vecs[v].frame, vecs[v].nbits);
            end_and_check($sformatf("vec%0d", v), vecs[v].exp_wv, vecs[v].exp_cf,
                          vecs[v].exp_fe, rd4, rd5);
            if (vecs[v].exp_wv) model_commit(vecs[v].frame[15:0]);
            check_state($sformatf("vec%0d", v));
        end

        // Reset in the middle of frame 0x1123, released while sync is still low
        start_frame();
        send_bits(32'h11, 8);
        rst = 1'b1;
        idle_clk(2);
        check("midreset word_out", word_out, 16'h0000);
        rst = 1'b0;
        model_reset();
        idle_clk(2);
        send_bits(32'h23, 8);
        end_and_check("midreset partial", 1'b0, 1'b0, 1'b0, rd4, rd5);
        check_state("midreset partial");

        start_frame();
        send_bits(32'h1456, 16);
        end_and_check("post-reset 0x1456", 1'b1, 1'b0, 1'b0, rd4, rd5);
        model_commit(16'h1456);
        check_state("post-reset 0x1456");

        // Eight back-to-back frames with a two-sclk gap; rd_addr held at 5 for frame 5
        for (int n = 0; n < 8; n++) begin
            fr = {1'b0, 3'(n), 12'(n + 1)};
            rd_addr = (n == 5) ? 3'd5 : 3'd0;
            start_frame();
            send_bits({16'h0000, fr}, 16);
            end_and_check($sformatf("b2b%0d", n), 1'b1, 1'b0, 1'b0, rd4, rd5);
            if (n == 5) begin
                check("b2b5 rd_data commit cycle", rd4, 12'h000);
                check("b2b5 rd_data next cycle",   rd5, 12'h006);
            end
            model_commit(fr);
            idle_clk(16);
        end
        check_state("b2b final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
